// File: rtl/pixel_fixed_block_buffer.sv
// Purpose: convert unsigned pixels to signed fixed point (optional JPEG level shift) and pack NUM_INTEGERS of them into one block.
// Latency: the block is presented (m_valid=1) right after the edge that accepts its last sample; one dead cycle per block.
// Backpressure: while a full block waits for m_ready, s_ready=0 and the block is held unchanged indefinitely.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous abort of a partial or held block (wins over handshakes)
//   shift_en        level-shift mode, captured with the first sample of each block
//   s_valid/s_ready/s_data   pixel input handshake
//   m_valid/m_ready/m_data   packed block output handshake, element i at [i*W +: W]
//   m_shifted       level-shift mode of the presented block
module pixel_fixed_block_buffer #(
    parameter int INT_BITS     = 16,
    parameter int FRAC_BITS    = 16,
    parameter int INPUT_BITS   = 8,
    parameter int NUM_INTEGERS = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 shift_en,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [INPUT_BITS-1:0]                s_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [NUM_INTEGERS*(INT_BITS+FRAC_BITS)-1:0] m_data,
    output logic                                 m_shifted
);

    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int IDX_W = $clog2(NUM_INTEGERS);
    localparam int EXT_W = INT_BITS - INPUT_BITS;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      mode_q;
    logic [NUM_INTEGERS*W-1:0] data_q;

    logic                      mode_d;
    logic [INT_BITS-1:0]       int_d;
    logic [W-1:0]              word_d;

    // The first sample of a block uses shift_en directly; the rest reuse the latched mode.
    // Subtracting 2^(INPUT_BITS-1) from an unsigned pixel is the same as inverting its MSB
    // and reading the result as signed, so the sign extension is the inverted MSB.
    always_comb begin
        mode_d = (idx_q == '0) ? shift_en : mode_q;
        if (mode_d) begin
            int_d = {{EXT_W{~s_data[INPUT_BITS-1]}}, ~s_data[INPUT_BITS-1], s_data[INPUT_BITS-2:0]};
        end else begin
            int_d = {{EXT_W{1'b0}}, s_data};
        end
        word_d = {int_d, {FRAC_BITS{1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            // Buffer contents are left as-is; only the fill position and state restart.
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (s_valid) begin
                        data_q[idx_q*W +: W] <= word_d;
                        mode_q               <= mode_d;
                        if (idx_q == IDX_W'(NUM_INTEGERS-1)) begin
                            idx_q   <= '0;
                            state_q <= FULL;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (m_ready) begin
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Handshake outputs depend on the state register only.
    assign s_ready   = (state_q == FILL);
    assign m_valid   = (state_q == FULL);
    assign m_data    = data_q;
    assign m_shifted = mode_q;

endmodule

// File: tb/tb_pixel_fixed_block_buffer.sv
module tb_pixel_fixed_block_buffer;

    localparam int N = 64;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           shift_en;
    logic           s_valid;
    logic           s_ready;
    logic [7:0]     s_data;
    logic           m_valid;
    logic           m_ready;
    logic [N*W-1:0] m_data;
    logic           m_shifted;

    pixel_fixed_block_buffer #(
        .INT_BITS(16), .FRAC_BITS(16), .INPUT_BITS(8), .NUM_INTEGERS(N)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .shift_en(shift_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_shifted(m_shifted)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: a count of collected samples, the pixels themselves, and whether a
    // finished block is waiting downstream.
    bit             full = 1'b0;
    int             cnt  = 0;
    bit             mode = 1'b0;
    logic [7:0]     pix [N];
    logic [N*W-1:0] exp_blk;
    bit             exp_sh;
    int             blocks_out = 0;

    function automatic logic [W-1:0] ref_word(input logic [7:0] p, input bit sh);
        longint v;
        v = sh ? (longint'(p) - 128) : longint'(p);
        v = v * 65536;
        return v[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_blk(input string tag);
        int bad;
        bad = 0;
        n_asserts++;
        assert (m_data === exp_blk) else begin
            n_fail++;
            for (int i = N - 1; i >= 0; i--)
                if (m_data[i*W +: W] !== exp_blk[i*W +: W]) bad = i;
            $error("FAIL %s: element %0d observed %h expected %h", tag, bad,
                   m_data[bad*W +: W], exp_blk[bad*W +: W]);
        end
    endtask

    // One clock: apply inputs, advance the model across the edge, then check outputs.
    task automatic cycle(input logic sv, input logic [7:0] sd, input logic se,
                         input logic mr, input logic clr);
        s_valid  = sv;
        s_data   = sd;
        shift_en = se;
        m_ready  = mr;
        clear    = clr;
        @(posedge clk);
        if (clr) begin
            cnt  = 0;
            full = 1'b0;
        end else if (!full) begin
            if (sv) begin
                if (cnt == 0) mode = se;
                pix[cnt] = sd;
                cnt++;
                if (cnt == N) begin
                    cnt    = 0;
                    full   = 1'b1;
                    exp_sh = mode;
                    for (int i = 0; i < N; i++) exp_blk[i*W +: W] = ref_word(pix[i], mode);
                end
            end
        end else if (mr) begin
            full = 1'b0;
            blocks_out++;
        end
        #1;
        chk("s_ready", 32'(s_ready), 32'(!full));
        chk("m_valid", 32'(m_valid), 32'(full));
        if (full) begin
            chk_blk("m_data");
            chk("m_shifted", 32'(m_shifted), 32'(exp_sh));
        end
    endtask

    task automatic fill_random(input bit sh, input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 8'($urandom_range(0, 255)), (i == 0) ? sh : 1'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        int start;
        int budget;

        rst = 1'b1; clear = 1'b0; shift_en = 1'b0; s_valid = 1'b0;
        s_data = 8'h00; m_ready = 1'b0;
        #12;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_shifted", 32'(m_shifted), 32'd0);
        n_asserts++;
        assert (m_data === '0) else begin
            n_fail++;
            $error("FAIL rst_m_data: observed nonzero expected zero");
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unshifted ramp 0..63, back-to-back.
        for (int i = 0; i < N; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("ramp_e0",  m_data[0*W +: W],  32'h0000_0000);
        chk("ramp_e1",  m_data[1*W +: W],  32'h0001_0000);
        chk("ramp_e63", m_data[63*W +: W], 32'h003F_0000);
        chk("ramp_shifted", 32'(m_shifted), 32'd0);

        // Back-pressure with s_valid high: nothing consumed, block stable.
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);

        // Shifted block, first sample right after the handoff edge; shift_en toggles afterwards.
        cycle(1'b1, 8'd0,   1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'd128, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'd200, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i < N; i++) cycle(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("sh_e0", m_data[0*W +: W], 32'hFF80_0000);
        chk("sh_e1", m_data[1*W +: W], 32'h0000_0000);
        chk("sh_e2", m_data[2*W +: W], 32'h007F_0000);
        chk("sh_e3", m_data[3*W +: W], 32'h0048_0000);
        chk("sh_shifted", 32'(m_shifted), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Bursty input and random downstream readiness, two blocks.
        for (int b = 0; b < 2; b++) begin
            start  = blocks_out;
            budget = 0;
            while (blocks_out == start && budget < 2000) begin
                cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
                budget++;
            end
            n_asserts++;
            assert (blocks_out != start) else begin
                n_fail++;
                $error("FAIL burst_timeout: observed no handoff expected block %0d", b);
            end
        end
        while (full) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // clear after 30 samples (with a discarded sample in the clear cycle), then a full block.
        fill_random(1'b0, 30);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        fill_random(1'b1, N);
        chk("clr_full", 32'(m_valid), 32'd1);

        // clear while full with m_ready high: block dropped, not handed off.
        start = blocks_out;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("clr_full_ready", 32'(s_ready), 32'd1);

        // Async reset between edges mid-fill.
        fill_random(1'b1, 10);
        #2;
        rst = 1'b1;
        #1;
        full = 1'b0; cnt = 0;
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        chk("arst_m_shifted", 32'(m_shifted), 32'd0);
        #1;
        rst = 1'b0;
        fill_random(1'b0, N);
        chk("arst_refill", 32'(m_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_fixed_block_buffer.md
# pixel_fixed_block_buffer

Streaming successor to the combinational integer-to-fixed-point converter. It accepts unsigned pixels one per cycle over a valid/ready handshake and converts each to signed two's-complement fixed point, with optional JPEG level shift (subtract 2^(INPUT_BITS-1)). It buffers NUM_INTEGERS converted samples into one packed block and presents that block to the downstream DCT stage over a second valid/ready handshake.

## Interface
- INT_BITS, 16, integer bits of output word (incl. sign); must be >= INPUT_BITS+1
- FRAC_BITS, 16, fractional bits of output word
- INPUT_BITS, 8, pixel width (unsigned)
- NUM_INTEGERS, 64, samples per block (>= 2)
- W (local), INT_BITS+FRAC_BITS, output word width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous abort: drop partial or held block
- shift_en  in  1  level-shift mode, sampled with the first sample of each block
- s_valid  in  1  input sample valid
- s_ready  out  1  input ready
- s_data  in  INPUT_BITS  unsigned pixel
- m_valid  out  1  block valid
- m_ready  in  1  downstream ready
- m_data  out  NUM_INTEGERS*W  packed block; element i at [i*W +: W], i = arrival order
- m_shifted  out  1  shift_en value latched for the presented block

## Operation
- States: FILL (collecting), FULL (holding a complete block).
- FILL: s_ready=1, m_valid=0. Each accepted sample (s_valid&&s_ready) is converted and written to slot idx. idx then increments.
- On acceptance at idx==0, latch shift_en into the block mode register. That mode applies to every sample of the block. shift_en is ignored at other times.
- On acceptance at idx==NUM_INTEGERS-1: idx wraps to 0 and the state goes to FULL.
- FULL: s_ready=0, m_valid=1, m_data and m_shifted stable. On m_valid&&m_ready the state returns to FILL. Buffer contents are not cleared.
- Conversion, unshifted: integer part = zero-extended pixel, fraction = 0, i.e. value = pixel·2^FRAC_BITS.
- Conversion, shifted: integer part = sign-extended (pixel − 2^(INPUT_BITS-1)), fraction = 0.
- No saturation is needed; the parameter rule guarantees range.
- clear=1: idx←0, state←FILL. It takes priority over any handshake in the same cycle; samples or block handoffs in that cycle are discarded. Buffer data is not zeroed.
- s_data arriving while s_valid=0 has no effect. s_valid while in FULL is back-pressured; the sample is not consumed.

## Timing
- Reset values: state=FILL, idx=0, m_valid=0, s_ready=1, m_shifted=0, m_data all zeros.
- s_ready and m_valid are decoded from the state register only. There is no combinational path from s_valid or m_ready.
- Fill latency: with last sample accepted at edge k, m_valid=1 from edge k through to the handshake edge.
- Block handoff at edge j (m_valid&&m_ready): s_ready=1 after edge j. The first sample of the next block can be accepted at edge j+1.
- Throughput: NUM_INTEGERS+1 cycles per block minimum, i.e. one dead cycle per block.
- m_ready held low: the block holds indefinitely, with no data change.
- Gaps in s_valid stall idx; partial blocks persist until completed or cleared.
- Async rst mid-fill or mid-hold: outputs return to reset values immediately. The partial block is lost.

## Test plan
- Reset, then unshifted fill with shift_en=0 and pixels 0..63 streaming back-to-back -> m_valid rises after the 64th acceptance; element 0=0x00000000, element 1=0x00010000, element 63=0x003F0000, m_shifted=0.
- Shifted block with shift_en=1 at first sample and pixels 0,128,255,200,... -> elements 0xFF800000, 0x00000000, 0x007F0000, 0x00480000, m_shifted=1. Toggling shift_en mid-block changes nothing.
- Back-pressure: m_ready=0 for 20 cycles while s_valid=1 -> s_ready=0, m_data stable, no samples consumed. Then m_ready=1 for one cycle -> next block's first sample is accepted on the following edge.
- Bursty input: s_valid random at 50% -> block content in arrival order and exactly 64 acceptances per block.
- clear during fill after 30 samples -> idx reset. The next 64 samples form a complete block, with none of the first 30 present. clear in FULL with m_ready=1 in the same cycle -> block dropped, state=FILL.
- Async rst asserted mid-fill, between clock edges -> m_valid=0 and s_ready=1 immediately. A fresh 64-sample block then completes correctly.
